// File: rtl/branch_target_buffer_pkg.sv
// Shared BTB definitions: counter encodings, control-flow opcodes, index/tag extraction.
// Optional gshare counter indexing is enabled by defining BTB_GSHARE_EN.
`ifndef BRANCH_TARGET_BUFFER_PKG_SV
`define BRANCH_TARGET_BUFFER_PKG_SV

// Index and tag fields of a word-aligned PC for a table of 2**ib entries
`define BTB_IDX(pc, ib) pc[(ib)+1:2]
`define BTB_TAG(pc, ib) pc[31:(ib)+2]

package branch_target_buffer_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    function automatic logic is_ctrl_flow(input logic [6:0] opcode);
        return (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_BRANCH);
    endfunction

    function automatic logic is_jump(input logic [6:0] opcode);
        return (opcode == OPC_JAL) || (opcode == OPC_JALR);
    endfunction

endpackage

`endif

// File: rtl/branch_target_buffer_sat_counter2.sv
// Combinational next state of a 2-bit saturating direction counter.
module branch_target_buffer_sat_counter2
    import branch_target_buffer_pkg::*;
(
    input  ctr_t ctr,
    input  logic inc,
    output ctr_t nxt
);

    always_comb begin
        nxt = ctr;
        if (inc) begin
            if (ctr != STRONG_T) nxt = ctr_t'(ctr + 2'd1);
        end else begin
            if (ctr != STRONG_NT) nxt = ctr_t'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer feeding pc_BTB to the branch hazard unit.
// Define BTB_GSHARE_EN to index the direction counters by idx ^ global history.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int INDEX_BITS = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] IF_pc,
    output logic [31:0] pc_BTB,
    output logic        pred_hit,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_is_jump
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic                  valid_q  [ENTRIES];
    logic                  jump_q   [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [31:0]           target_q [ENTRIES];
    ctr_t                  ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] rd_idx, up_idx, rd_cidx, up_cidx;
    logic [TAG_BITS-1:0]   rd_tag, up_tag;
    logic                  up_hit;
    logic                  ctr_wr_en;
    ctr_t                  ctr_rd, ctr_trained, ctr_new;
    logic [31:0]           pc_plus4;
    logic                  unused_pc_lsbs;

    assign rd_idx = `BTB_IDX(IF_pc, INDEX_BITS);
    assign rd_tag = `BTB_TAG(IF_pc, INDEX_BITS);
    assign up_idx = `BTB_IDX(upd_pc, INDEX_BITS);
    assign up_tag = `BTB_TAG(upd_pc, INDEX_BITS);
    assign unused_pc_lsbs = ^{IF_pc[1:0], upd_pc[1:0]};

`ifdef BTB_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q;

    assign rd_cidx = rd_idx ^ ghr_q;
    assign up_cidx = up_idx ^ ghr_q;

    // Jumps are predicted by their jump bit alone, so they leave the shared counters alone
    assign ctr_wr_en = !upd_is_jump;
    assign ctr_new   = ctr_trained;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr_q <= '0;
        end else if (upd_valid && !upd_is_jump) begin
            ghr_q <= {ghr_q[INDEX_BITS-2:0], upd_taken};
        end
    end
`else
    assign rd_cidx   = rd_idx;
    assign up_cidx   = up_idx;
    assign ctr_wr_en = 1'b1;

    always_comb begin
        ctr_new = ctr_trained;
        if (upd_is_jump)  ctr_new = STRONG_T;
        else if (!up_hit) ctr_new = upd_taken ? WEAK_T : WEAK_NT;
    end
`endif

    // Combinational read path
    assign ctr_rd     = ctr_q[rd_cidx];
    assign pred_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pred_taken = pred_hit && (jump_q[rd_idx] || ctr_rd == WEAK_T || ctr_rd == STRONG_T);
    assign pc_plus4   = IF_pc + 32'd4;
    assign pc_BTB     = pred_taken ? target_q[rd_idx] : pc_plus4;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    branch_target_buffer_sat_counter2 u_sat_counter2 (
        .ctr (ctr_q[up_cidx]),
        .inc (upd_taken),
        .nxt (ctr_trained)
    );

    // Update path: hit and miss both rewrite target/jump; a miss also claims the entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                jump_q[i]   <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WEAK_NT;
            end
        end else if (upd_valid) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target;
            jump_q[up_idx]   <= upd_is_jump;
            if (ctr_wr_en) ctr_q[up_cidx] <= ctr_new;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (default build).
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] IF_pc;
    logic [31:0] pc_BTB;
    logic        pred_hit;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_is_jump;

    int n_checks = 0;
    int n_fail   = 0;

    branch_target_buffer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .IF_pc       (IF_pc),
        .pc_BTB      (pc_BTB),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .upd_is_jump (upd_is_jump)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic taken, input logic jmp);
        @(negedge clk);
        upd_valid   = 1'b1;
        upd_pc      = pc;
        upd_target  = tgt;
        upd_taken   = taken;
        upd_is_jump = jmp;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [31:0] pc,
                         input logic hit, input logic tkn, input logic [31:0] nxt);
        IF_pc = pc;
        #1;
        check({tag, "_hit"},   {31'd0, pred_hit},   {31'd0, hit});
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tkn});
        check({tag, "_pc"},    pc_BTB,              nxt);
    endtask

    initial begin
        reset_n     = 1'b0;
        IF_pc       = 32'h40;
        upd_valid   = 1'b0;
        upd_pc      = '0;
        upd_target  = '0;
        upd_taken   = 1'b0;
        upd_is_jump = 1'b0;
        probe("rst", 32'h40, 1'b0, 1'b0, 32'h44);
        @(negedge clk);
        reset_n = 1'b1;

        // Branch at 0x40 walks the counter: alloc 10, dec 01, inc 10, 11, saturate 11
        do_upd(32'h40, 32'h100, 1'b1, 1'b0);
        probe("br_alloc", 32'h40, 1'b1, 1'b1, 32'h100);
        do_upd(32'h40, 32'h100, 1'b0, 1'b0);
        probe("br_nt", 32'h40, 1'b1, 1'b0, 32'h44);
        do_upd(32'h40, 32'h100, 1'b1, 1'b0);
        probe("br_t1", 32'h40, 1'b1, 1'b1, 32'h100);
        do_upd(32'h40, 32'h100, 1'b1, 1'b0);
        do_upd(32'h40, 32'h100, 1'b1, 1'b0);
        do_upd(32'h40, 32'h100, 1'b0, 1'b0);
        probe("br_sat", 32'h40, 1'b1, 1'b1, 32'h100);
        do_upd(32'h40, 32'h100, 1'b0, 1'b0);
        probe("br_dec2", 32'h40, 1'b1, 1'b0, 32'h44);

        // Jumps predict taken regardless of upd_taken
        do_upd(32'h80, 32'h20, 1'b1, 1'b1);
        probe("jal", 32'h80, 1'b1, 1'b1, 32'h20);
        do_upd(32'h80, 32'h20, 1'b0, 1'b1);
        probe("jal_nt", 32'h80, 1'b1, 1'b1, 32'h20);

        // Alias eviction at index 16
        do_upd(32'h40, 32'h100, 1'b1, 1'b0);
        do_upd(32'hC0, 32'h200, 1'b1, 1'b0);
        probe("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
        probe("alias_new", 32'hC0, 1'b1, 1'b1, 32'h200);

        // Same-cycle read/write returns pre-update contents
        do_upd(32'h40, 32'h100, 1'b1, 1'b0);
        @(negedge clk);
        IF_pc       = 32'h40;
        upd_valid   = 1'b1;
        upd_pc      = 32'h40;
        upd_target  = 32'h300;
        upd_taken   = 1'b1;
        upd_is_jump = 1'b0;
        #1;
        check("rw_same_cycle", pc_BTB, 32'h100);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        check("rw_next_cycle", pc_BTB, 32'h300);

        probe("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        // upd_valid low must not write
        @(negedge clk);
        upd_pc      = 32'h80;
        upd_target  = 32'h999;
        upd_is_jump = 1'b1;
        upd_taken   = 1'b1;
        @(posedge clk);
        #1;
        probe("no_upd", 32'h80, 1'b1, 1'b1, 32'h20);

        // Low PC bits of the update are ignored
        do_upd(32'h83, 32'h24, 1'b1, 1'b1);
        probe("pc_lsb", 32'h80, 1'b1, 1'b1, 32'h24);

        // Asynchronous reset mid-run, away from any clock edge
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        probe("arst_40", 32'h40, 1'b0, 1'b0, 32'h44);
        probe("arst_80", 32'h80, 1'b0, 1'b0, 32'h84);
        @(negedge clk);
        reset_n = 1'b1;
        probe("post_rst", 32'hC0, 1'b0, 1'b0, 32'hC4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
